// File: rtl/ahbl_apb_bridge_multi.sv
// AHB-Lite to APB4 bridge with up to 16 decoded APB slots,
// byte strobes, decode-error and access-timeout responses.
module ahbl_apb_bridge_multi #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLOTS  = 16,
  parameter int SLOT_LSB   = 8,
  parameter int TIMEOUT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [NUM_SLOTS-1:0]  PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic                  bad_q, bad_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic [NUM_SLOTS-1:0]  psel_q, psel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic                  penable_q, penable_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;

  logic                  accept;
  logic [3:0]            slot_in;
  logic                  bad_in;
  logic [NUM_SLOTS-1:0]  slot_dec;
  logic [3:0]            strb;
  logic                  to_hit;
  logic                  unused;

  assign unused  = HTRANS[0];
  assign accept  = HSEL & HTRANS[1] & HREADYIN;
  assign slot_in = HADDR[SLOT_LSB+3:SLOT_LSB];
  assign bad_in  = ({1'b0, slot_in} >= 5'(NUM_SLOTS)) |
                   (HSIZE > 3'd2);
  assign slot_dec = NUM_SLOTS'(1) <<
                    addr_q[SLOT_LSB+3:SLOT_LSB];
  assign to_hit  = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  always_comb begin
    strb = 4'h0;
    if (write_q) begin
      unique case (1'b1)
        size_q == 3'd0: strb = 4'h1 << addr_q[1:0];
        size_q == 3'd1: strb = addr_q[1] ? 4'hC : 4'h3;
        size_q == 3'd2: strb = 4'hF;
        default:        strb = 4'h0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_d = S_LATCH;
          addr_d  = HADDR;
          write_d = HWRITE;
          size_d  = HSIZE;
          bad_d   = bad_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        pwdata_d = HWDATA;
        pstrb_d  = strb;
        if (bad_q) begin
          state_d = S_ERR1;
        end else begin
          state_d  = S_SETUP;
          paddr_d  = addr_q;
          pwrite_d = write_q;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (PREADY) begin
          state_d = PSLVERR ? S_ERR1 : S_DONE;
          cnt_d   = '0;
          if (!PSLVERR && !write_q) hrdata_d = PRDATA;
        end else if (to_hit) begin
          state_d = S_ERR1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered
  always_comb begin
    hready_d  = (state_d == S_IDLE) ||
                (state_d == S_DONE) ||
                (state_d == S_ERR2);
    hresp_d   = (state_d == S_ERR1) ||
                (state_d == S_ERR2);
    penable_d = (state_d == S_ACCESS);
    psel_d    = '0;
    if ((state_d == S_SETUP) || (state_d == S_ACCESS))
      psel_d = slot_dec;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      bad_q     <= 1'b0;
      cnt_q     <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      hrdata_q  <= '0;
      psel_q    <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      bad_q     <= bad_d;
      cnt_q     <= cnt_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      psel_q    <= psel_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
    end
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule
